// File: rtl/local_memory_arbiter_if.sv
// Requester and SRAM-side signal bundle for local_memory_arbiter.
// The slave modport is the arbiter's view; master is the clients plus the memory.
interface local_memory_arbiter_if #(
    parameter int unsigned W_WIDTH = 16,
    parameter int unsigned W_ADDR  = 10
);
    logic               a_req;
    logic               a_we;
    logic [W_ADDR-1:0]  a_addr;
    logic [W_WIDTH-1:0] a_wdata;
    logic               a_gnt;
    logic               a_rvalid;
    logic [W_WIDTH-1:0] a_rdata;

    logic               b_req;
    logic               b_we;
    logic [W_ADDR-1:0]  b_addr;
    logic [W_WIDTH-1:0] b_wdata;
    logic               b_gnt;
    logic               b_rvalid;
    logic [W_WIDTH-1:0] b_rdata;

    logic [W_WIDTH-1:0] mem_data;
    logic [W_ADDR-1:0]  mem_wraddress;
    logic               mem_wren;
    logic [W_ADDR-1:0]  mem_rdaddress;
    logic [W_WIDTH-1:0] mem_q;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_data, mem_wraddress, mem_wren, mem_rdaddress,
        input  mem_q
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_data, mem_wraddress, mem_wren, mem_rdaddress,
        output mem_q
    );
endinterface

// File: rtl/local_memory_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of a dual-port SRAM.
// One access per cycle is accepted; reads are tagged with their owner and the
// returning data is steered back to the requester that issued it.
module local_memory_arbiter #(
    parameter int unsigned W_WIDTH = 16,
    parameter int unsigned W_ADDR  = 10,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                   MCLK,
    input  logic                   RST,
    local_memory_arbiter_if.slave  bus
);

    typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

    owner_t             last_grant;
    logic               wren_q;
    logic [W_ADDR-1:0]  wraddr_q;
    logic [W_WIDTH-1:0] wdata_q;
    logic [W_ADDR-1:0]  rdaddr_q;

    logic [RD_LAT:0]    tag_valid;
    logic [RD_LAT:0]    tag_own_b;

    logic               a_rvalid_q;
    logic               b_rvalid_q;
    logic [W_WIDTH-1:0] a_rdata_q;
    logic [W_WIDTH-1:0] b_rdata_q;

    logic               a_elig;
    logic               b_elig;
    logic               grant_a;
    logic               grant_b;
    logic               xfer;
    logic               sel_we;
    logic [W_ADDR-1:0]  sel_addr;
    logic [W_WIDTH-1:0] sel_wdata;

    // A read to the address being written this cycle is held off one cycle so it sees the new data.
    always_comb begin
        a_elig = bus.a_req &&
                 (bus.a_we || !(wren_q && (wraddr_q == bus.a_addr)));
        b_elig = bus.b_req &&
                 (bus.b_we || !(wren_q && (wraddr_q == bus.b_addr)));
    end

    // Round-robin grant: a tie goes to the requester that was not granted last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!RST) begin
            if (a_elig && b_elig) begin
                if (last_grant == OWN_B) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (a_elig) begin
                grant_a = 1'b1;
            end else if (b_elig) begin
                grant_b = 1'b1;
            end
        end
    end

    // Select the winning requester's command.
    always_comb begin
        xfer      = grant_a || grant_b;
        sel_we    = grant_a ? bus.a_we    : bus.b_we;
        sel_addr  = grant_a ? bus.a_addr  : bus.b_addr;
        sel_wdata = grant_a ? bus.a_wdata : bus.b_wdata;
    end

    // Issue stage: register the accepted command onto the SRAM ports and track the last winner.
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            last_grant <= OWN_B;
            wren_q     <= 1'b0;
            wraddr_q   <= '0;
            wdata_q    <= '0;
            rdaddr_q   <= '0;
        end else begin
            wren_q <= xfer && sel_we;
            if (xfer) begin
                last_grant <= grant_a ? OWN_A : OWN_B;
                if (sel_we) begin
                    wraddr_q <= sel_addr;
                    wdata_q  <= sel_wdata;
                end else begin
                    rdaddr_q <= sel_addr;
                end
            end
        end
    end

    // Tag pipeline: stage k holds the read issued k+1 edges ago, so stage RD_LAT lines up with mem_q.
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            tag_valid <= '0;
            tag_own_b <= '0;
        end else begin
            tag_valid <= {tag_valid[RD_LAT-1:0], xfer && !sel_we};
            tag_own_b <= {tag_own_b[RD_LAT-1:0], grant_b};
        end
    end

    // Read return: capture mem_q for the owning requester and pulse its rvalid.
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= tag_valid[RD_LAT] && !tag_own_b[RD_LAT];
            b_rvalid_q <= tag_valid[RD_LAT] &&  tag_own_b[RD_LAT];
            if (tag_valid[RD_LAT] && !tag_own_b[RD_LAT]) begin
                a_rdata_q <= bus.mem_q;
            end
            if (tag_valid[RD_LAT] && tag_own_b[RD_LAT]) begin
                b_rdata_q <= bus.mem_q;
            end
        end
    end

    assign bus.a_gnt         = grant_a;
    assign bus.b_gnt         = grant_b;
    assign bus.a_rvalid      = a_rvalid_q;
    assign bus.b_rvalid      = b_rvalid_q;
    assign bus.a_rdata       = a_rdata_q;
    assign bus.b_rdata       = b_rdata_q;
    assign bus.mem_wren      = wren_q;
    assign bus.mem_wraddress = wraddr_q;
    assign bus.mem_data      = wdata_q;
    assign bus.mem_rdaddress = rdaddr_q;

endmodule

// File: tb/tb_local_memory_arbiter.sv
// Bench for local_memory_arbiter (RD_LAT=1) with a behavioural SRAM and a
// queue-based reference model checked every cycle, plus directed scenarios.
module tb_local_memory_arbiter;

    logic MCLK = 1'b0;
    logic RST  = 1'b1;

    always #5 MCLK = ~MCLK;

    local_memory_arbiter_if #(.W_WIDTH(16), .W_ADDR(10)) bus ();

    local_memory_arbiter #(.W_WIDTH(16), .W_ADDR(10), .RD_LAT(1)) dut (
        .MCLK (MCLK),
        .RST  (RST),
        .bus  (bus)
    );

    function automatic logic [15:0] init_word(input int i);
        return 16'hC000 ^ 16'(i * 257);
    endfunction

    // Behavioural SRAM: registered read, one cycle latency.
    logic [15:0]   sram [0:1023];
    logic [1023:0] sram_wr = '0;
    always @(posedge MCLK) begin
        if (bus.mem_wren) begin
            sram[bus.mem_wraddress]    <= bus.mem_data;
            sram_wr[bus.mem_wraddress] <= 1'b1;
        end
        bus.mem_q <= sram_wr[bus.mem_rdaddress] ? sram[bus.mem_rdaddress]
                                                : init_word(int'(bus.mem_rdaddress));
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Observations gathered by the monitor for the directed scenarios.
    int          a_rv_cnt = 0;
    int          b_rv_cnt = 0;
    logic [15:0] a_last = '0;
    logic [15:0] b_last = '0;
    int          b_run = 0;
    int          b_run_max = 0;

    typedef struct {
        logic        own_b;
        logic [15:0] data;
        int          due;
    } ret_t;

    // Reference model: grants from the arbitration rules, reads resolved against
    // a model memory at grant time and returned 3 cycles later in issue order.
    task automatic monitor();
        logic [15:0] ref_mem [0:1023];
        ret_t        rq [$];
        ret_t        r;
        int          cyc = 0;
        logic        last_a = 1'b0;
        logic        prev_wr_v = 1'b0;
        logic [9:0]  prev_wr_addr = '0;
        logic [15:0] prev_wr_data = '0;
        logic        pend_rd_v = 1'b0;
        logic [9:0]  pend_rd_addr = '0;
        logic        exp_wren;
        logic [9:0]  exp_wraddr = '0;
        logic [15:0] exp_wdata = '0;
        logic [9:0]  exp_rdaddr = '0;
        logic [15:0] exp_a_rdata = '0;
        logic [15:0] exp_b_rdata = '0;
        logic        a_el, b_el, ea, eb, era, erb, we;
        logic [9:0]  addr;
        logic [15:0] wd;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge MCLK);
            if (RST) begin
                chk("rst_a_gnt", bus.a_gnt, 0);
                chk("rst_b_gnt", bus.b_gnt, 0);
                chk("rst_a_rvalid", bus.a_rvalid, 0);
                chk("rst_b_rvalid", bus.b_rvalid, 0);
                chk("rst_a_rdata", bus.a_rdata, 0);
                chk("rst_b_rdata", bus.b_rdata, 0);
                chk("rst_mem_wren", bus.mem_wren, 0);
                chk("rst_mem_wraddress", bus.mem_wraddress, 0);
                chk("rst_mem_rdaddress", bus.mem_rdaddress, 0);
                chk("rst_mem_data", bus.mem_data, 0);
                rq.delete();
                last_a = 1'b0; prev_wr_v = 1'b0; pend_rd_v = 1'b0;
                exp_wraddr = '0; exp_wdata = '0; exp_rdaddr = '0;
                exp_a_rdata = '0; exp_b_rdata = '0;
                b_run = 0;
            end else begin
                if (pend_rd_v) begin
                    exp_rdaddr = pend_rd_addr;
                    pend_rd_v  = 1'b0;
                end
                exp_wren = prev_wr_v;
                if (prev_wr_v) begin
                    exp_wraddr = prev_wr_addr;
                    exp_wdata  = prev_wr_data;
                    prev_wr_v  = 1'b0;
                end
                a_el = bus.a_req && (bus.a_we || !(exp_wren && exp_wraddr == bus.a_addr));
                b_el = bus.b_req && (bus.b_we || !(exp_wren && exp_wraddr == bus.b_addr));
                ea = a_el && (!b_el || !last_a);
                eb = b_el && !ea;
                chk("a_gnt", bus.a_gnt, ea);
                chk("b_gnt", bus.b_gnt, eb);
                chk("mem_wren", bus.mem_wren, exp_wren);
                chk("mem_wraddress", bus.mem_wraddress, exp_wraddr);
                chk("mem_data", bus.mem_data, exp_wdata);
                chk("mem_rdaddress", bus.mem_rdaddress, exp_rdaddr);
                era = 1'b0;
                erb = 1'b0;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    r = rq.pop_front();
                    if (r.own_b) begin
                        erb = 1'b1;
                        exp_b_rdata = r.data;
                    end else begin
                        era = 1'b1;
                        exp_a_rdata = r.data;
                    end
                end
                chk("a_rvalid", bus.a_rvalid, era);
                chk("b_rvalid", bus.b_rvalid, erb);
                chk("a_rdata", bus.a_rdata, exp_a_rdata);
                chk("b_rdata", bus.b_rdata, exp_b_rdata);
                if (bus.a_rvalid) begin
                    a_rv_cnt++;
                    a_last = bus.a_rdata;
                end
                if (bus.b_rvalid) begin
                    b_rv_cnt++;
                    b_last = bus.b_rdata;
                    b_run++;
                    if (b_run > b_run_max) b_run_max = b_run;
                end else begin
                    b_run = 0;
                end
                if (ea || eb) begin
                    we   = ea ? bus.a_we    : bus.b_we;
                    addr = ea ? bus.a_addr  : bus.b_addr;
                    wd   = ea ? bus.a_wdata : bus.b_wdata;
                    if (we) begin
                        ref_mem[addr] = wd;
                        prev_wr_v    = 1'b1;
                        prev_wr_addr = addr;
                        prev_wr_data = wd;
                    end else begin
                        rq.push_back('{own_b: eb, data: ref_mem[addr], due: cyc + 3});
                        pend_rd_v    = 1'b1;
                        pend_rd_addr = addr;
                    end
                    last_a = ea;
                end
                cyc++;
            end
        end
    endtask

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic do_reset();
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        step();
        RST = 1'b1;
        repeat (2) @(posedge MCLK);
        #1;
        RST = 1'b0;
    endtask

    // Issue one A access and hold it until granted; reports stall cycles.
    task automatic a_xfer(input logic we, input logic [9:0] addr, input logic [15:0] wd,
                          output int waited);
        logic got = 1'b0;
        bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
        waited = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge MCLK);
            if (bus.a_gnt) begin
                got = 1'b1;
                break;
            end
            waited++;
            step();
        end
        chk("a_grant_within_bound", got, 1);
        step();
        bus.a_req = 1'b0;
    endtask

    task automatic b_xfer(input logic we, input logic [9:0] addr, input logic [15:0] wd,
                          output int waited);
        logic got = 1'b0;
        bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
        waited = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge MCLK);
            if (bus.b_gnt) begin
                got = 1'b1;
                break;
            end
            waited++;
            step();
        end
        chk("b_grant_within_bound", got, 1);
        step();
        bus.b_req = 1'b0;
    endtask

    initial begin
        int w1, w2, na, nb, cycles, idx;
        logic [5:0] pat_a, pat_b;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge MCLK);
        #1;
        RST = 1'b0;

        // 1: write then read-after-write to the same address.
        a_xfer(1'b1, 10'd5, 16'h1234, w1);
        chk("t1_write_wait", w1, 0);
        chk("t1_mem_wren", bus.mem_wren, 1);
        chk("t1_mem_wraddress", bus.mem_wraddress, 5);
        chk("t1_mem_data", bus.mem_data, 16'h1234);
        na = a_rv_cnt;
        a_xfer(1'b0, 10'd5, 16'h0000, w2);
        chk("t1_read_stall", w2, 1);
        repeat (5) step();
        chk("t1_a_rvalid_count", a_rv_cnt - na, 1);
        chk("t1_a_rdata", a_last, 16'h1234);

        // 2: both requesters hold reads; strict alternation.
        do_reset();
        na = a_rv_cnt; nb = b_rv_cnt;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 10'd1;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 10'd2;
        pat_a = '0; pat_b = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge MCLK);
            pat_a = {pat_a[4:0], bus.a_gnt};
            pat_b = {pat_b[4:0], bus.b_gnt};
            step();
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        chk("t2_a_grant_pattern", pat_a, 6'b101010);
        chk("t2_b_grant_pattern", pat_b, 6'b010101);
        repeat (5) step();
        chk("t2_a_rvalid_count", a_rv_cnt - na, 3);
        chk("t2_b_rvalid_count", b_rv_cnt - nb, 3);
        chk("t2_a_rdata", a_last, init_word(1));
        chk("t2_b_rdata", b_last, init_word(2));

        // 3: B alone, back-to-back reads of addresses 0..7.
        do_reset();
        na = a_rv_cnt; nb = b_rv_cnt;
        idx = 0; cycles = 0;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 10'd0;
        while (idx < 8 && cycles < 30) begin
            @(negedge MCLK);
            if (bus.b_gnt) idx++;
            cycles++;
            step();
            bus.b_addr = 10'(idx);
        end
        bus.b_req = 1'b0;
        chk("t3_issue_cycles", cycles, 8);
        repeat (5) step();
        chk("t3_b_rvalid_count", b_rv_cnt - nb, 8);
        chk("t3_b_rvalid_run", b_run_max, 8);
        chk("t3_a_rvalid_count", a_rv_cnt - na, 0);
        chk("t3_b_last_rdata", b_last, init_word(7));

        // 4: A writes addr 3 while B reads addr 3 in the same cycle.
        do_reset();
        nb = b_rv_cnt;
        fork
            a_xfer(1'b1, 10'd3, 16'hAAAA, w1);
            b_xfer(1'b0, 10'd3, 16'h0000, w2);
        join
        chk("t4_a_wait", w1, 0);
        chk("t4_b_wait", w2, 2);
        repeat (5) step();
        chk("t4_b_rvalid_count", b_rv_cnt - nb, 1);
        chk("t4_b_rdata", b_last, 16'hAAAA);

        // 5: reset in the cycle after a read grant.
        do_reset();
        a_xfer(1'b0, 10'd9, 16'h0000, w1);
        bus.a_req = 1'b1; bus.a_addr = 10'd1;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 10'd2;
        RST = 1'b1;
        #1;
        chk("t5_a_gnt_in_reset", bus.a_gnt, 0);
        chk("t5_b_gnt_in_reset", bus.b_gnt, 0);
        chk("t5_rdaddress_in_reset", bus.mem_rdaddress, 0);
        chk("t5_wren_in_reset", bus.mem_wren, 0);
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        step();
        RST = 1'b0;
        na = a_rv_cnt; nb = b_rv_cnt;
        repeat (6) step();
        chk("t5_a_rvalid_after_reset", a_rv_cnt - na, 0);
        chk("t5_b_rvalid_after_reset", b_rv_cnt - nb, 0);
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 10'd1;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 10'd2;
        @(negedge MCLK);
        chk("t5_tie_a_gnt", bus.a_gnt, 1);
        chk("t5_tie_b_gnt", bus.b_gnt, 0);
        step();
        bus.a_req = 1'b0;
        step();
        bus.b_req = 1'b0;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
